operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Register-read stage between decode and execute. Drives the register file read addresses,
//  captures both operands and bypasses same-cycle writeback data. A busy scoreboard of pending
//  writes stalls read-after-write and write-after-write hazards. Output is one registered
//  valid/ready slot feeding execute.
// PARAMETERS
//  XLEN       32  operand/data width
//  NREG       32  architectural registers; register 0 reads as zero and is never busy
//  PAYLOAD_W  32  opaque decode payload passed through unchanged (opcode, imm, pc...)
// PORTS
//  clk          in   1          clock, all state updates on rising edge
//  rst_n        in   1          asynchronous active-low reset
//  in_valid     in   1          decode presents an instruction
//  in_ready     out  1          stage accepts the instruction this cycle
//  in_rs0       in   REG_AW     source register 0 (REG_AW = $clog2(NREG))
//  in_rs1       in   REG_AW     source register 1
//  in_rd        in   REG_AW     destination register
//  in_rd_we     in   1          instruction writes in_rd
//  in_payload   in   PAYLOAD_W  pass-through payload
//  rf_r_reg0    out  REG_AW     regfile read address 0 (= in_rs0, combinational)
//  rf_r_reg1    out  REG_AW     regfile read address 1 (= in_rs1, combinational)
//  rf_r_dat0    in   XLEN       regfile read data 0 (combinational read)
//  rf_r_dat1    in   XLEN       regfile read data 1
//  wb_valid     in   1          writeback this cycle (same signals drive regfile write)
//  wb_reg       in   REG_AW     writeback register
//  wb_dat       in   XLEN       writeback data
//  flush        in   1          squash the instruction held in the output slot
//  out_valid    out  1          operands valid to execute
//  out_ready    in   1          execute accepts
//  out_op0      out  XLEN       operand 0
//  out_op1      out  XLEN       operand 1
//  out_rd       out  REG_AW     destination register
//  out_rd_we    out  1          destination write enable
//  out_payload  out  PAYLOAD_W  payload
// BEHAVIOUR
//  - Reset: out_valid=0, out_op0/op1/rd/rd_we/payload=0, busy[NREG-1:0]=0. A mid-operation
//    reset drops the held instruction immediately.
//  - Bypass, per source rs: value = 0 if rs==0; else wb_dat if wb_valid && wb_reg==rs;
//    else rf_r_dat.
//  - Effective busy: ebusy(r) = busy[r] && !(wb_valid && wb_reg==r).
//  - hazard = ebusy(rs0) | ebusy(rs1) | (in_rd_we && in_rd!=0 && ebusy(in_rd)).
//    Register 0 never hazards.
//  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
//  - Issue = in_valid && in_ready. It loads the output slot with the bypassed operands and
//    the fields, and sets out_valid=1. Latency is 1 cycle, full throughput when there are
//    no hazards.
//  - If out_ready=1 and there is no issue, out_valid <= 0. The slot holds steady while
//    out_valid && !out_ready.
//  - Scoreboard, per cycle:
//    - wb_valid && wb_reg!=0 clears busy[wb_reg].
//    - Issue with in_rd_we && in_rd!=0 sets busy[in_rd].
//    - Set wins over a clear of the same register in the same cycle.
//    - wb_valid to a non-busy register is legal and has no effect.
//  - Flush: out_valid <= 0. If out_valid && out_rd_we, busy[out_rd] is cleared. No issue
//    happens that cycle. Flush takes priority over out_ready.
//  - WAW stall guarantees at most one pending write per register, so busy is a plain bit.
// STRUCTURE
//  - risc_pkg: XLEN, NREG, REG_AW, typedefs reg_addr_t and word_t.
//  - Sub-module reg_scoreboard: busy vector with set/clear ports and set-over-clear
//    priority. It exposes ebusy lookups for three addresses.
//  - Top level holds the bypass muxes, the hazard and handshake logic, and the output slot.
// TESTING
//  1. Reset with rst_n=0 mid-stream -> out_valid=0, all busy=0, in_ready=1 after release.
//  2. Preload x5=7, x6=9; issue add rs0=5 rs1=6 rd=7 -> next cycle out_op0=7, out_op1=9,
//     busy[7]=1.
//  3. Issue rd=7; next instruction reads rs0=7 -> in_ready=0 until wb_valid, wb_reg=7,
//     wb_dat=42. Issue happens in that wb cycle with out_op0=42 the following cycle.
//  4. rs0=0 while rf_r_dat0=0xDEAD -> out_op0=0. rd=0 with rd_we=1 -> busy unchanged,
//     no stall.
//  5. out_ready=0 for 3 cycles with in_valid=1 -> output fields stable, in_ready=0,
//     no instruction lost or duplicated.
//  6. Slot holds rd=9, rd_we=1; assert flush -> out_valid=0 next cycle, busy[9]=0,
//     no issue that cycle.
//  7. Random stream of 500 instructions vs. a reference model with a randomly delayed
//     writeback -> every operand matches architectural order.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared widths, register/word types, the output-slot payload and the bypass select helper
// for the register-read stage.
package risc_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NREG      = 32;
  localparam int unsigned REG_AW    = $clog2(NREG);
  localparam int unsigned PAYLOAD_W = 32;

  typedef logic [REG_AW-1:0]    reg_addr_t;
  typedef logic [XLEN-1:0]      word_t;
  typedef logic [PAYLOAD_W-1:0] payload_t;

  typedef struct packed {
    word_t     op0;
    word_t     op1;
    reg_addr_t rd;
    logic      rd_we;
    payload_t  payload;
  } slot_t;

  // x0 reads as zero; a same-cycle writeback beats the stale regfile read
  function automatic word_t bypass_sel(input reg_addr_t rs, input logic wb_v,
                                       input reg_addr_t wb_r, input word_t wb_d,
                                       input word_t rf_d);
    word_t v;
    v = rf_d;
    if (rs == '0)                  v = '0;
    else if (wb_v && (wb_r == rs)) v = wb_d;
    return v;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy bit per architectural register tracking an outstanding write. Set wins over clear;
// lookups ignore a bit that is being cleared by this cycle's writeback.
module reg_scoreboard
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_set,
  input  logic [REG_AW-1:0] i_set_reg,
  input  logic              i_wb_clr,
  input  logic [REG_AW-1:0] i_wb_clr_reg,
  input  logic              i_fl_clr,
  input  logic [REG_AW-1:0] i_fl_clr_reg,
  input  logic [REG_AW-1:0] i_q0,
  input  logic [REG_AW-1:0] i_q1,
  input  logic [REG_AW-1:0] i_q2,
  output logic              o_ebusy0_c,
  output logic              o_ebusy1_c,
  output logic              o_ebusy2_c
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    if (i_wb_clr) w_busy_nxt[i_wb_clr_reg] = 1'b0;
    if (i_fl_clr) w_busy_nxt[i_fl_clr_reg] = 1'b0;
    if (i_set)    w_busy_nxt[i_set_reg]    = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign o_ebusy0_c = r_busy[i_q0] && !(i_wb_clr && (i_wb_clr_reg == i_q0));
  assign o_ebusy1_c = r_busy[i_q1] && !(i_wb_clr && (i_wb_clr_reg == i_q1));
  assign o_ebusy2_c = r_busy[i_q2] && !(i_wb_clr && (i_wb_clr_reg == i_q2));

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: regfile addressing, writeback bypass, RAW/WAW hazard stall and a
// single registered valid/ready slot toward execute.
module operand_fetch
  import risc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_AW-1:0]    in_rs0,
  input  logic [REG_AW-1:0]    in_rs1,
  input  logic [REG_AW-1:0]    in_rd,
  input  logic                 in_rd_we,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic [REG_AW-1:0]    rf_r_reg0,
  output logic [REG_AW-1:0]    rf_r_reg1,
  input  logic [XLEN-1:0]      rf_r_dat0,
  input  logic [XLEN-1:0]      rf_r_dat1,
  input  logic                 wb_valid,
  input  logic [REG_AW-1:0]    wb_reg,
  input  logic [XLEN-1:0]      wb_dat,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_op0,
  output logic [XLEN-1:0]      out_op1,
  output logic [REG_AW-1:0]    out_rd,
  output logic                 out_rd_we,
  output logic [PAYLOAD_W-1:0] out_payload
);

  logic  r_valid;
  slot_t r_slot;

  logic  w_ebusy0, w_ebusy1, w_ebusy2;
  logic  w_hazard, w_ready, w_issue;
  logic  w_rd_nz, w_set, w_wb_clr, w_fl_clr;
  word_t w_op0, w_op1;

  assign rf_r_reg0 = in_rs0;
  assign rf_r_reg1 = in_rs1;

  assign w_op0 = bypass_sel(in_rs0, wb_valid, wb_reg, wb_dat, rf_r_dat0);
  assign w_op1 = bypass_sel(in_rs1, wb_valid, wb_reg, wb_dat, rf_r_dat1);

  // RAW on either source, WAW on the destination; x0 is never busy
  assign w_rd_nz  = (in_rd != '0);
  assign w_hazard = w_ebusy0 | w_ebusy1 | (in_rd_we && w_rd_nz && w_ebusy2);
  assign w_ready  = (!r_valid || out_ready) && !w_hazard && !flush;
  assign w_issue  = in_valid && w_ready;
  assign in_ready = w_ready;

  assign w_set    = w_issue && in_rd_we && w_rd_nz;
  assign w_wb_clr = wb_valid && (wb_reg != '0);
  assign w_fl_clr = flush && r_valid && r_slot.rd_we;

  reg_scoreboard u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_set        (w_set),
    .i_set_reg    (in_rd),
    .i_wb_clr     (w_wb_clr),
    .i_wb_clr_reg (wb_reg),
    .i_fl_clr     (w_fl_clr),
    .i_fl_clr_reg (r_slot.rd),
    .i_q0         (in_rs0),
    .i_q1         (in_rs1),
    .i_q2         (in_rd),
    .o_ebusy0_c   (w_ebusy0),
    .o_ebusy1_c   (w_ebusy1),
    .o_ebusy2_c   (w_ebusy2)
  );

  // Output slot: flush squashes, issue loads, otherwise drains on out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_slot  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_issue) begin
      r_valid        <= 1'b1;
      r_slot.op0     <= w_op0;
      r_slot.op1     <= w_op1;
      r_slot.rd      <= in_rd;
      r_slot.rd_we   <= in_rd_we;
      r_slot.payload <= in_payload;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_op0     = r_slot.op0;
  assign out_op1     = r_slot.op1;
  assign out_rd      = r_slot.rd;
  assign out_rd_we   = r_slot.rd_we;
  assign out_payload = r_slot.payload;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed and random stimulus for operand_fetch; expected slots come from a program-order
// architectural model and are checked by an independent output monitor.
module tb_operand_fetch;
  import risc_pkg::*;

  logic      clk, rst_n;
  logic      in_valid, in_ready, in_rd_we, wb_valid, flush, out_valid, out_ready, out_rd_we;
  reg_addr_t in_rs0, in_rs1, in_rd, rf_r_reg0, rf_r_reg1, wb_reg, out_rd;
  word_t     rf_r_dat0, rf_r_dat1, wb_dat, out_op0, out_op1;
  payload_t  in_payload, out_payload;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs0(in_rs0), .in_rs1(in_rs1), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_payload(in_payload), .rf_r_reg0(rf_r_reg0), .rf_r_reg1(rf_r_reg1),
    .rf_r_dat0(rf_r_dat0), .rf_r_dat1(rf_r_dat1), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .wb_dat(wb_dat), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_op0(out_op0), .out_op1(out_op1), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_payload(out_payload)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    word_t     op0;
    word_t     op1;
    reg_addr_t rd;
    logic      we;
    payload_t  payload;
    word_t     res;
  } exp_t;

  typedef struct packed {
    reg_addr_t   r;
    word_t       d;
    logic [31:0] due;
  } pend_t;

  word_t       rf   [NREG];
  word_t       arch [NREG];
  exp_t        exp_q [$];
  pend_t       pend_q [$];
  int          vectors, miscompares;
  logic [31:0] cyc;
  logic [NREG-1:0] busy_v;

  logic      drv_valid, drv_we, drv_ordy, drv_flush, auto_wb, man_wb, issued;
  reg_addr_t drv_rs0, drv_rs1, drv_rd, man_reg;
  payload_t  drv_payload;
  word_t     drv_res, man_dat;

  assign rf_r_dat0 = rf[rf_r_reg0];
  assign rf_r_dat1 = rf[rf_r_reg1];
  assign busy_v    = dut.u_sb.r_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sync_arch();
    for (int i = 0; i < int'(NREG); i++) arch[i] = rf[i];
    arch[0] = '0;
  endtask

  task automatic set_instr(input int rs0, input int rs1, input int rd, input logic we,
                           input int pl, input word_t res);
    drv_rs0 = reg_addr_t'(rs0); drv_rs1 = reg_addr_t'(rs1); drv_rd = reg_addr_t'(rd);
    drv_we = we; drv_payload = PAYLOAD_W'(pl); drv_res = res; drv_valid = 1'b1;
  endtask

  // One cycle: commit last writeback to the model regfile, drive inputs, then decide issue
  task automatic step();
    @(negedge clk);
    if (wb_valid && (wb_reg != '0)) rf[wb_reg] = wb_dat;
    cyc++;
    in_valid = drv_valid; in_rs0 = drv_rs0; in_rs1 = drv_rs1; in_rd = drv_rd;
    in_rd_we = drv_we; in_payload = drv_payload; out_ready = drv_ordy; flush = drv_flush;
    wb_valid = 1'b0; wb_reg = '0; wb_dat = '0;
    if (man_wb) begin
      wb_valid = 1'b1; wb_reg = man_reg; wb_dat = man_dat; man_wb = 1'b0;
    end else if (auto_wb) begin
      for (int i = 0; i < pend_q.size(); i++) begin
        if (pend_q[i].due <= cyc) begin
          wb_valid = 1'b1; wb_reg = pend_q[i].r; wb_dat = pend_q[i].d;
          pend_q.delete(i);
          break;
        end
      end
    end
    #2;
    issued = in_valid && in_ready;
    if (issued) begin
      exp_t e;
      e.op0 = arch[in_rs0]; e.op1 = arch[in_rs1]; e.rd = in_rd; e.we = in_rd_we;
      e.payload = in_payload; e.res = drv_res;
      exp_q.push_back(e);
      if (in_rd_we && (in_rd != '0)) arch[in_rd] = drv_res;
    end
  endtask

  // Output monitor: every accepted slot must match the oldest expected entry
  always @(negedge clk) begin
    exp_t me;
    #3;
    if (rst_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_out: got payload 0x%0h expected none", out_payload);
      end else begin
        me = exp_q.pop_front();
        check("out_op0",     64'(out_op0),     64'(me.op0));
        check("out_op1",     64'(out_op1),     64'(me.op1));
        check("out_rd",      64'(out_rd),      64'(me.rd));
        check("out_rd_we",   64'(out_rd_we),   64'(me.we));
        check("out_payload", 64'(out_payload), 64'(me.payload));
        if (auto_wb && me.we && (me.rd != '0))
          pend_q.push_back('{me.rd, me.res, cyc + 32'($urandom_range(0, 4))});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tries;
    vectors = 0; miscompares = 0; cyc = '0;
    drv_valid = 0; drv_we = 0; drv_ordy = 1; drv_flush = 0; auto_wb = 0; man_wb = 0;
    drv_rs0 = '0; drv_rs1 = '0; drv_rd = '0; drv_payload = '0; drv_res = '0;
    man_reg = '0; man_dat = '0; issued = 0;
    wb_valid = 0; wb_reg = '0; wb_dat = '0;
    for (int i = 0; i < int'(NREG); i++) rf[i] = word_t'(32'h100 + i);
    rf[0] = 32'hDEAD;
    sync_arch();
    rst_n = 1'b0;

    // Reset state
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy",      64'(busy_v),    64'(0));
    check("rst_op0",       64'(out_op0),   64'(0));
    check("rst_payload",   64'(out_payload), 64'(0));
    rst_n = 1'b1;

    // Mid-stream reset drops the held instruction and its busy bit
    set_instr(1, 2, 3, 1, 'h100, 32'h33);
    step();
    drv_valid = 0; drv_ordy = 0;
    step();
    check("t1_held_valid", 64'(out_valid), 64'(1));
    check("t1_busy3",      64'(busy_v[3]), 64'(1));
    rst_n = 1'b0;
    #1;
    check("t1_rst_valid", 64'(out_valid), 64'(0));
    check("t1_rst_busy",  64'(busy_v),    64'(0));
    exp_q.delete();
    sync_arch();
    drv_ordy = 1;
    step();
    rst_n = 1'b1;
    #1;
    check("t1_in_ready", 64'(in_ready), 64'(1));

    // Basic issue with operands from the regfile
    rf[5] = 32'd7; rf[6] = 32'd9; sync_arch();
    set_instr(5, 6, 7, 1, 'hADD, 32'd42);
    step();
    check("t2_issue", 64'(issued), 64'(1));
    drv_valid = 0;
    step();
    check("t2_op0",   64'(out_op0),   64'(7));
    check("t2_op1",   64'(out_op1),   64'(9));
    check("t2_busy7", 64'(busy_v[7]), 64'(1));

    // RAW stall released by the same-cycle writeback, which is bypassed
    set_instr(7, 0, 8, 0, 'h3, 32'h0);
    step();
    check("t3_stall0", 64'(in_ready), 64'(0));
    step();
    check("t3_stall1", 64'(in_ready), 64'(0));
    man_wb = 1; man_reg = reg_addr_t'(7); man_dat = 32'd42;
    step();
    check("t3_issue_on_wb", 64'(issued), 64'(1));
    drv_valid = 0;
    step();
    check("t3_op0",   64'(out_op0),   64'(42));
    check("t3_busy7", 64'(busy_v[7]), 64'(0));

    // x0 reads zero and never becomes busy
    set_instr(0, 5, 0, 1, 'h4, 32'h77);
    step();
    check("t4_issue0", 64'(issued), 64'(1));
    set_instr(0, 0, 0, 1, 'h5, 32'h78);
    step();
    check("t4_issue1",  64'(issued),  64'(1));
    check("t4_rs0_zero", 64'(out_op0), 64'(0));
    check("t4_op1",     64'(out_op1), 64'(7));
    check("t4_busy",    64'(busy_v),  64'(0));
    drv_valid = 0;
    step();
    check("t4_op0_b", 64'(out_op0), 64'(0));

    // Backpressure holds the slot steady
    set_instr(5, 6, 10, 0, 'h51, 32'h0);
    step();
    set_instr(6, 5, 11, 0, 'h52, 32'h0);
    drv_ordy = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_in_ready", 64'(in_ready),    64'(0));
      check("t5_valid",    64'(out_valid),   64'(1));
      check("t5_payload",  64'(out_payload), 64'(32'h51));
      check("t5_op0",      64'(out_op0),     64'(7));
    end
    drv_ordy = 1;
    step();
    check("t5_issue_b", 64'(issued), 64'(1));
    drv_valid = 0;
    step(); step();
    check("t5_no_loss", 64'(exp_q.size()), 64'(0));

    // Flush squashes the held rd=9 writer and releases its busy bit
    set_instr(1, 2, 9, 1, 'h69, 32'h99);
    drv_ordy = 0;
    step();
    check("t6_issue", 64'(issued), 64'(1));
    set_instr(3, 0, 12, 0, 'h6A, 32'h0);
    drv_flush = 1;
    step();
    check("t6_no_issue", 64'(issued),   64'(0));
    check("t6_ready",    64'(in_ready), 64'(0));
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    drv_flush = 0; drv_valid = 0; drv_ordy = 1;
    step();
    check("t6_valid", 64'(out_valid), 64'(0));
    check("t6_busy9", 64'(busy_v[9]), 64'(0));
    check("t6_busy",  64'(busy_v),    64'(0));
    sync_arch();

    // Random stream against the architectural model with delayed writeback
    auto_wb = 1;
    for (int n = 0; n < 500; n++) begin
      set_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), logic'($urandom_range(0, 3) != 0),
                n | 'h1000, $urandom);
      tries = 0;
      do begin
        drv_ordy = ($urandom_range(0, 3) != 0);
        step();
        tries++;
      end while (!issued && tries < 100);
      if (!issued) begin
        vectors++; miscompares++;
        $display("FAIL rand_issue_timeout: got no issue expected issue of %0d", n);
        break;
      end
    end
    drv_valid = 0; drv_ordy = 1;
    tries = 0;
    while ((exp_q.size() != 0 || pend_q.size() != 0) && tries < 300) begin
      step();
      tries++;
    end
    step();
    check("rand_drain", 64'(exp_q.size() + pend_q.size()), 64'(0));
    check("rand_busy",  64'(busy_v), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
